// File: rtl/play_input_decoder.sv
// Player button front end: 2-flop synchroniser, debounce, single-button check, valid/ready colour events.
// Optional macro PLAY_ECHO_EN drives o_btn_echo with the held button; without it o_btn_echo is tied low.
module play_input_decoder #(
   parameter int DEBOUNCE_CYCLES = 2000000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic [3:0] i_play_button,
   output logic       o_press_valid,
   output logic [1:0] o_press_color,
   input  logic       i_press_ready,
   output logic       o_press_error,
   output logic       o_overrun,
   output logic [3:0] o_btn_echo
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_REL,
      IDLE,
      DEB_PRESS,
      HELD,
      DEB_REL
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync_vec_q, sync_vec_d;
   logic [3:0]       prev_q, prev_d;
   logic [3:0]       key_q, key_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [1:0]       color_q, color_d;
   logic             error_q, error_d;
   logic             overrun_q, overrun_d;

   logic changed;
   logic stable;
   logic settled;
   logic one_hot;

   function automatic logic [1:0] encode(input logic [3:0] vec);
      case (vec)
         4'b0010: encode = 2'd1;
         4'b0100: encode = 2'd2;
         4'b1000: encode = 2'd3;
         default: encode = 2'd0;
      endcase
   endfunction

   always_comb begin
      // NOTE: every *_d gets a default first so no path through this block can infer a latch.
      sync1_d    = i_play_button;
      sync_vec_d = sync1_q;
      prev_d     = sync_vec_q;
      state_d    = state_q;
      key_d      = key_q;
      color_d    = color_q;
      error_d    = 1'b0;
      overrun_d  = 1'b0;
      valid_d    = valid_q && !i_press_ready;

      changed = (sync_vec_q != prev_q);
      stable  = !changed && (cnt_q == CNT_LAST);
      settled = !changed && (cnt_q >= CNT_LAST);
      one_hot = (sync_vec_q != 4'b0000) && ((sync_vec_q & (sync_vec_q - 4'd1)) == 4'b0000);

      if (changed)
         cnt_d = '0;
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;

      if (!i_enable) begin
         state_d = WAIT_REL;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            // A long-settled zero vector also releases us, otherwise a saturated counter would never re-arm.
            WAIT_REL: begin
               if (settled && (sync_vec_q == 4'b0000))
                  state_d = IDLE;
            end
            IDLE: begin
               if (sync_vec_q != 4'b0000) begin
                  state_d = DEB_PRESS;
                  cnt_d   = '0;
               end
            end
            DEB_PRESS: begin
               if (stable) begin
                  if (one_hot) begin
                     state_d = HELD;
                     key_d   = sync_vec_q;
                     if (!valid_d) begin
                        valid_d = 1'b1;
                        color_d = encode(sync_vec_q);
                     end else begin
                        overrun_d = 1'b1;
                     end
                  end else if (sync_vec_q == 4'b0000) begin
                     state_d = IDLE;
                  end else begin
                     error_d = 1'b1;
                     state_d = WAIT_REL;
                  end
               end
            end
            HELD: begin
               if (sync_vec_q != key_q)
                  state_d = DEB_REL;
            end
            DEB_REL: begin
               if (stable)
                  state_d = (sync_vec_q == 4'b0000) ? IDLE : WAIT_REL;
            end
            default: state_d = WAIT_REL;
         endcase
      end
   end

`ifdef PLAY_ECHO_EN
   logic [3:0] echo_q, echo_d;

   always_comb begin
      echo_d = ((state_d == HELD) || (state_d == DEB_REL)) ? key_d : 4'b0000;
   end
`endif

   // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= WAIT_REL;
         sync1_q    <= '0;
         sync_vec_q <= '0;
         prev_q     <= '0;
         key_q      <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         color_q    <= '0;
         error_q    <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef PLAY_ECHO_EN
         echo_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync_vec_q <= sync_vec_d;
         prev_q     <= prev_d;
         key_q      <= key_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         color_q    <= color_d;
         error_q    <= error_d;
         overrun_q  <= overrun_d;
`ifdef PLAY_ECHO_EN
         echo_q     <= echo_d;
`endif
      end
   end

   assign o_press_valid = valid_q;
   assign o_press_color = color_q;
   assign o_press_error = error_q;
   assign o_overrun     = overrun_q;

`ifdef PLAY_ECHO_EN
   assign o_btn_echo = echo_q;
`else
   assign o_btn_echo = 4'b0000;
`endif

endmodule

// File: tb/tb_play_input_decoder.sv
// Bench for play_input_decoder (DEBOUNCE_CYCLES=4): per-cycle model comparison plus directed literal checks.
module tb_play_input_decoder;

   localparam int D = 4;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_enable = 1'b0;
   logic [3:0] i_play_button = 4'b0000;
   logic       i_press_ready = 1'b0;
   logic       o_press_valid;
   logic [1:0] o_press_color;
   logic       o_press_error;
   logic       o_overrun;
   logic [3:0] o_btn_echo;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   int xfer_colors[$];
   int xfer_cycs[$];
   int err_cnt = 0;
   int ovr_cnt = 0;

   play_input_decoder #(.DEBOUNCE_CYCLES(D)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_enable      (i_enable),
      .i_play_button (i_play_button),
      .o_press_valid (o_press_valid),
      .o_press_color (o_press_color),
      .i_press_ready (i_press_ready),
      .o_press_error (o_press_error),
      .o_overrun     (o_overrun),
      .o_btn_echo    (o_btn_echo)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {PH_LOCKED, PH_ARMED, PH_PRESSING, PH_HOLDING, PH_RELEASING} phase_t;

   phase_t     ph;
   logic [3:0] m_s1, m_sync, m_key;
   int         m_run;          // cycles the synchronised vector has shown its current value, this one included
   logic       e_valid, e_err, e_ovr;
   logic [1:0] e_color;
   logic [3:0] e_echo;

   task model_reset();
      ph      = PH_LOCKED;
      m_s1    = 4'b0000;
      m_sync  = 4'b0000;
      m_key   = 4'b0000;
      m_run   = 2;             // the cleared filter counts the first post-reset cycle as already one cycle old
      e_valid = 1'b0;
      e_err   = 1'b0;
      e_ovr   = 1'b0;
      e_color = 2'd0;
      e_echo  = 4'b0000;
   endtask

   task model_step();
      bit stable, settled;
      stable  = (m_run == D + 1);
      settled = (m_run >= D + 1);
      e_err = 1'b0;
      e_ovr = 1'b0;
      if (e_valid && i_press_ready) e_valid = 1'b0;
      if (!i_enable) begin
         ph = PH_LOCKED;
         e_valid = 1'b0;
      end else begin
         case (ph)
            PH_LOCKED:   if (settled && m_sync == 4'b0000) ph = PH_ARMED;
            PH_ARMED:    if (m_sync != 4'b0000) ph = PH_PRESSING;
            PH_PRESSING: if (stable) begin
               if ($countones(m_sync) == 1) begin
                  ph = PH_HOLDING;
                  m_key = m_sync;
                  if (!e_valid) begin
                     e_valid = 1'b1;
                     for (int i = 0; i < 4; i++) if (m_sync[i]) e_color = 2'(i);
                  end else begin
                     e_ovr = 1'b1;
                  end
               end else if (m_sync == 4'b0000) begin
                  ph = PH_ARMED;
               end else begin
                  e_err = 1'b1;
                  ph = PH_LOCKED;
               end
            end
            PH_HOLDING:  if (m_sync != m_key) ph = PH_RELEASING;
            PH_RELEASING: if (stable) ph = (m_sync == 4'b0000) ? PH_ARMED : PH_LOCKED;
            default: ph = PH_LOCKED;
         endcase
      end
`ifdef PLAY_ECHO_EN
      e_echo = (ph == PH_HOLDING || ph == PH_RELEASING) ? m_key : 4'b0000;
`else
      e_echo = 4'b0000;
`endif
      m_run  = (m_s1 == m_sync) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
      m_sync = m_s1;
      m_s1   = i_play_button;
   endtask

   // Compare process: outputs are checked mid-cycle, away from the rising edge.
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         check("rst_valid", 32'(o_press_valid), 32'd0);
         check("rst_color", 32'(o_press_color), 32'd0);
         check("rst_error", 32'(o_press_error), 32'd0);
         check("rst_overrun", 32'(o_overrun), 32'd0);
         check("rst_echo", 32'(o_btn_echo), 32'd0);
         model_reset();
      end else begin
         check("valid", 32'(o_press_valid), 32'(e_valid));
         if (e_valid) check("color", 32'(o_press_color), 32'(e_color));
         check("error", 32'(o_press_error), 32'(e_err));
         check("overrun", 32'(o_overrun), 32'(e_ovr));
         check("echo", 32'(o_btn_echo), 32'(e_echo));
         if (o_press_valid && i_press_ready) begin
            xfer_colors.push_back(int'(o_press_color));
            xfer_cycs.push_back(cyc);
         end
         if (o_press_error) err_cnt++;
         if (o_overrun) ovr_cnt++;
         model_step();
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input int n);
      i_play_button = v;
      tick(n);
   endtask

   function automatic int xcol(input int idx);
      return (xfer_colors.size() > idx) ? xfer_colors[idx] : -1;
   endfunction

   function automatic int xcyc(input int idx);
      return (xfer_cycs.size() > idx) ? xfer_cycs[idx] : -1;
   endfunction

   initial begin
      int base, p, e0, o0;
      logic [3:0] echo_exp;

      tick(3);
      i_rst_n = 1'b1;
      tick(2);
      i_enable = 1'b1;
      i_press_ready = 1'b1;
      tick(10);

      // Single red press: one pulse, colour 2, valid 7 edges after the press
      base = xfer_colors.size();
      p = cyc;
      drive(4'b0100, 9);
`ifdef PLAY_ECHO_EN
      echo_exp = 4'b0100;
`else
      echo_exp = 4'b0000;
`endif
      check("s1_echo_held", 32'(o_btn_echo), 32'(echo_exp));
      drive(4'b0100, 11);
      drive(4'b0000, 15);
      check("s1_event_count", 32'(xfer_colors.size() - base), 32'd1);
      check("s1_color", 32'(xcol(base)), 32'd2);
      check("s1_latency", 32'(xcyc(base) - p), 32'd7);
      check("s1_echo_released", 32'(o_btn_echo), 32'd0);

      base = xfer_colors.size();
      drive(4'b0001, 12);
      drive(4'b0000, 15);
      check("s1b_event_count", 32'(xfer_colors.size() - base), 32'd1);
      check("s1b_color", 32'(xcol(base)), 32'd0);

      // Bouncing blue: nothing during the bounce, one event 7 edges after it settles
      base = xfer_colors.size();
      for (int i = 0; i < 3; i++) begin
         drive(4'b1000, 2);
         drive(4'b0000, 2);
      end
      check("s2_no_event_bounce", 32'(xfer_colors.size() - base), 32'd0);
      p = cyc;
      drive(4'b1000, 15);
      drive(4'b0000, 15);
      check("s2_event_count", 32'(xfer_colors.size() - base), 32'd1);
      check("s2_color", 32'(xcol(base)), 32'd3);
      check("s2_latency", 32'(xcyc(base) - p), 32'd7);

      // Two buttons: one error pulse, then nothing until a full release
      base = xfer_colors.size();
      e0 = err_cnt;
      drive(4'b0011, 15);
      check("s3_error_pulses", 32'(err_cnt - e0), 32'd1);
      drive(4'b0010, 15);
      check("s3_no_event_unreleased", 32'(xfer_colors.size() - base), 32'd0);
      drive(4'b0000, 15);
      drive(4'b0010, 12);
      drive(4'b0000, 15);
      check("s3_event_count", 32'(xfer_colors.size() - base), 32'd1);
      check("s3_color", 32'(xcol(base)), 32'd1);
      check("s3_error_total", 32'(err_cnt - e0), 32'd1);

      // Backpressure: second press is dropped with one overrun pulse
      i_press_ready = 1'b0;
      o0 = ovr_cnt;
      drive(4'b0001, 12);
      drive(4'b0000, 12);
      drive(4'b0100, 12);
      drive(4'b0000, 12);
      check("s4_valid_held", 32'(o_press_valid), 32'd1);
      check("s4_color_kept", 32'(o_press_color), 32'd0);
      check("s4_overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
      base = xfer_colors.size();
      i_press_ready = 1'b1;
      tick(3);
      check("s4_transfer_count", 32'(xfer_colors.size() - base), 32'd1);
      check("s4_transfer_color", 32'(xcol(base)), 32'd0);
      check("s4_valid_dropped", 32'(o_press_valid), 32'd0);

      // Button held across enable rising never produces an event
      base = xfer_colors.size();
      e0 = err_cnt;
      o0 = ovr_cnt;
      i_enable = 1'b0;
      drive(4'b0010, 5);
      i_enable = 1'b1;
      drive(4'b0010, 15);
      drive(4'b0000, 15);
      check("s5_no_event", 32'(xfer_colors.size() - base), 32'd0);
      check("s5_no_pulses", 32'((err_cnt - e0) + (ovr_cnt - o0)), 32'd0);

      // Dropping enable clears a pending event on the next edge
      i_press_ready = 1'b0;
      drive(4'b0001, 12);
      check("s5_valid_pending", 32'(o_press_valid), 32'd1);
      i_enable = 1'b0;
      tick(1);
      check("s5_enable_drop_valid", 32'(o_press_valid), 32'd0);
      drive(4'b0000, 10);
      i_enable = 1'b1;
      tick(10);

      // Asynchronous reset in the middle of a press debounce
      drive(4'b0001, 12);
      drive(4'b0000, 12);
      drive(4'b0100, 4);
      check("s6_valid_before_reset", 32'(o_press_valid), 32'd1);
      #1;
      i_rst_n = 1'b0;
      #1;
      check("s6_async_valid", 32'(o_press_valid), 32'd0);
      check("s6_async_color", 32'(o_press_color), 32'd0);
      check("s6_async_error", 32'(o_press_error), 32'd0);
      check("s6_async_overrun", 32'(o_overrun), 32'd0);
      check("s6_async_echo", 32'(o_btn_echo), 32'd0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      i_press_ready = 1'b1;
      drive(4'b0000, 10);
      base = xfer_colors.size();
      drive(4'b0100, 12);
      drive(4'b0000, 12);
      check("s6_post_reset_count", 32'(xfer_colors.size() - base), 32'd1);
      check("s6_post_reset_color", 32'(xcol(base)), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/play_input_decoder.md
Name: play_input_decoder

Overview:
- Input-side counterpart to the LED/sequence output path.
- Takes the four raw player buttons (green, yellow, red, blue) from the pins, then synchronises and debounces them.
- Validates that exactly one button is pressed and delivers one colour event per physical press to the game FSM over a valid/ready handshake.
- Sits between the chip pins and fsm_module's player-input logic.

Parameters:
DEBOUNCE_CYCLES, 2000000, cycles a sampled button vector must stay stable before it is accepted (10 ms at 200 MHz); minimum 2
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
i_clk  in  1  device clock, 200 MHz, posedge
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  FSM is in the player-input phase; presses are accepted only while high
i_play_button  in  4  raw async buttons [0:Green,1:Yellow,2:Red,3:Blue], active-high
o_press_valid  out  1  colour event pending
o_press_color  out  2  encoded colour: 0 Green, 1 Yellow, 2 Red, 3 Blue
i_press_ready  in  1  FSM consumes the event
o_press_error  out  1  1-cycle pulse: stable multi-button press detected
o_overrun  out  1  1-cycle pulse: confirmed press discarded because the previous event was unconsumed
o_btn_echo  out  4  one-hot echo of the held button (see Optional Feature)

Behaviour:
- Reset: every output is 0, the FSM is in WAIT_REL, the sync flops and counter are 0. Reset is applied asynchronously and released on the clock.
- Synchroniser: two flops per bit. sync_vec is the second stage.
- Debounce: the counter clears whenever sync_vec differs from its value on the previous cycle. Otherwise it increments, saturating at DEBOUNCE_CYCLES. "stable" means counter == DEBOUNCE_CYCLES-1 and sync_vec is unchanged on that cycle.
- FSM states and transitions:
  - WAIT_REL: wait for all buttons released. When sync_vec==0 and stable, and i_enable=1, go to IDLE.
  - IDLE: sync_vec!=0 → DEB_PRESS, with the counter cleared.
  - DEB_PRESS: any change in sync_vec restarts the count. On stable:
    - If the vector is one-hot, latch the colour and go to HELD.
    - If the vector is zero, return to IDLE.
    - If more than one bit is set, pulse o_press_error for 1 cycle and go to WAIT_REL.
  - HELD: sync_vec != latched one-hot → DEB_REL.
  - DEB_REL: on stable zero → IDLE. On stable nonzero → WAIT_REL, with no new event.
- i_enable=0 in any state:
  - Next state is WAIT_REL.
  - o_press_valid is cleared next cycle.
  - No error or overrun pulses are generated.
  - A button held across i_enable rising never generates an event.
- Event generation happens on the DEB_PRESS→HELD transition:
  - If o_press_valid=0, or (o_press_valid=1 and i_press_ready=1) on that same cycle, load o_press_color and set o_press_valid next cycle.
  - If o_press_valid=1 and i_press_ready=0, keep the old event, discard the new one, and pulse o_overrun.
- Handshake rules:
  - A transfer occurs on a cycle where o_press_valid=1 and i_press_ready=1.
  - o_press_valid drops the next cycle unless reloaded.
  - o_press_color is stable while o_press_valid=1.
  - Ready may be high before valid with no effect.
- Latency: with a raw button stable from clock edge N, o_press_valid is high at edge N+DEBOUNCE_CYCLES+3.

Optional Feature:
- Macro: PLAY_ECHO_EN.
- Defined: o_btn_echo = latched one-hot while in HELD or DEB_REL, and 0 otherwise. This lets the top level light the pressed colour LED.
- Undefined: o_btn_echo is tied to 4'b0000, and no echo register is synthesised.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4.)
- Reset then enable, raw 4'b0100 held 20 cycles with ready=1 → single o_press_valid pulse, color=2, at edge +7 from press. Release, then a second press of 4'b0001 → color=0.
- Raw 4'b1000 toggling every 2 cycles for 12 cycles, then steady → no event during the bounce; exactly one event, color=3, after 4 stable cycles.
- Raw 4'b0011 held → o_press_error one pulse, no valid. Then 4'b0010 without release → nothing until all released; after release, a fresh 4'b0010 → color=1.
- ready=0, press 4'b0001 and release, press 4'b0100 → valid stays with color=0 and o_overrun pulses once. Then ready=1 → one transfer of color=0, and valid drops.
- Button 4'b0010 held while i_enable rises → no event. Drop i_enable while valid pending → valid=0 next cycle. Assert i_rst_n=0 mid-DEB_PRESS → all outputs 0 immediately.
- With PLAY_ECHO_EN, hold 4'b0100 → o_btn_echo=4'b0100 from HELD until DEB_REL exits. Without the macro → o_btn_echo always 0.
